// File: rtl/matrix_bus_pkg.sv
// matrix_bus_pkg: shared state encoding and requester indices for the matrix bus arbiter
package matrix_bus_pkg;

    typedef enum logic [1:0] {IDLE, TURN, OWN, REL} arb_state_t;

    localparam int NUM_BUS_REQ = 5;
    localparam int REQ_EXEC    = 0;
    localparam int REQ_IMEM    = 1;
    localparam int REQ_MMEM    = 2;
    localparam int REQ_REGS    = 3;
    localparam int REQ_ALU     = 4;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin picker, first set request strictly after ptr, wrapping
module rr_pick #(
    parameter int N = 5,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    logic [N-1:0] rot;
    logic [W-1:0] first;

    // rotate so that bit 0 is the requester just after ptr
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++)
            rot[i] = req[W'((int'(ptr) + 1 + i) % N)];
    end

    // lowest set bit of the rotated vector, mapped back to a requester index
    always_comb begin
        first = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) first = W'(i);
        valid = |req;
        idx   = W'((int'(ptr) + 1 + int'(first)) % N);
    end

endmodule

// File: rtl/matrix_bus_arbiter.sv
// matrix_bus_arbiter: round-robin owner scheduler with turnaround and bounded hold for the matrix bus
module matrix_bus_arbiter
    import matrix_bus_pkg::*;
#(
    parameter int NUM_REQ  = NUM_BUS_REQ,
    parameter int MAX_HOLD = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         drive_en,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_t         state, state_n;
    logic [IW-1:0]      ptr, ptr_n, owner_n, pick;
    logic [HW-1:0]      hold, hold_n;
    logic [NUM_REQ-1:0] grant_n, drive_n;
    logic               terr_n, pick_valid, own_req, own_done, at_limit;

    rr_pick #(.N(NUM_REQ), .W(IW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick)
    );

    assign own_req  = req[owner];
    assign own_done = done[owner];
    assign at_limit = hold == HW'(MAX_HOLD);
    assign busy     = state != IDLE;

    // state and output registers; reset drops every enable immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= IW'(NUM_REQ - 1);
            owner       <= IW'(NUM_REQ - 1);
            hold        <= '0;
            grant       <= '0;
            drive_en    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            owner       <= owner_n;
            hold        <= hold_n;
            grant       <= grant_n;
            drive_en    <= drive_n;
            timeout_err <= terr_n;
        end
    end

    // next state: arbitrate in IDLE, quiet turnaround on both sides of OWN
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        hold_n  = hold;
        grant_n = grant;
        drive_n = drive_en;
        terr_n  = 1'b0;
        case (state)
            IDLE: if (pick_valid) begin
                state_n = TURN;
                owner_n = pick;
                grant_n = NUM_REQ'(1) << pick;
            end
            TURN: if (own_req) begin
                state_n = OWN;
                drive_n = grant;
                hold_n  = HW'(1);
            end else begin
                state_n = REL;
                grant_n = '0;
            end
            OWN: begin
                hold_n = at_limit ? hold : hold + 1'b1;
                if (own_done || !own_req || at_limit) begin
                    state_n = REL;
                    ptr_n   = owner;
                    grant_n = '0;
                    drive_n = '0;
                    terr_n  = at_limit && own_req && !own_done;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_matrix_bus_arbiter.sv
// tb_matrix_bus_arbiter: directed scoreboard bench for the matrix bus arbiter
module tb_matrix_bus_arbiter;
    import matrix_bus_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] req   = '0;
    logic [4:0] done  = '0;
    logic [4:0] grant, drive_en;
    logic [2:0] owner;
    logic       busy, timeout_err;

    typedef struct packed {
        logic [4:0] g;
        logic [4:0] d;
        logic [2:0] o;
        logic       b;
        logic       t;
    } exp_t;

    exp_t  sb[$];
    string tags[$];
    int    n_pass  = 0;
    int    n_total = 0;

    matrix_bus_arbiter #(.NUM_REQ(5), .MAX_HOLD(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .drive_en    (drive_en),
        .owner       (owner),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input logic [4:0] g, input logic [4:0] d, input logic [2:0] o,
                                input logic b, input logic t);
        exp_t e;
        e.g = g; e.d = d; e.o = o; e.b = b; e.t = t;
        return e;
    endfunction

    task automatic compare_all(input string tag, input exp_t e);
        chk({tag, " grant"}, 8'(grant), 8'(e.g));
        chk({tag, " drive_en"}, 8'(drive_en), 8'(e.d));
        chk({tag, " owner"}, 8'(owner), 8'(e.o));
        chk({tag, " busy"}, 8'(busy), 8'(e.b));
        chk({tag, " timeout_err"}, 8'(timeout_err), 8'(e.t));
    endtask

    task automatic step(input logic [4:0] r, input logic [4:0] d, input string tag, input exp_t e);
        exp_t  x;
        string t;
        req  = r;
        done = d;
        sb.push_back(e);
        tags.push_back(tag);
        @(negedge clock);
        x = sb.pop_front();
        t = tags.pop_front();
        compare_all(t, x);
    endtask

    task automatic xfer(input logic [4:0] r, input int o, input int n_own, input string tag);
        logic [4:0] oh;
        oh = 5'(1) << o;
        step(r, 5'b0, {tag, " turn"}, mk(oh, 5'b0, 3'(o), 1'b1, 1'b0));
        step(r, 5'b0, {tag, " own"}, mk(oh, oh, 3'(o), 1'b1, 1'b0));
        for (int k = 1; k < n_own; k++)
            step(r, 5'b0, {tag, " hold"}, mk(oh, oh, 3'(o), 1'b1, 1'b0));
        step(r, oh, {tag, " rel"}, mk(5'b0, 5'b0, 3'(o), 1'b1, 1'b0));
        step(r, 5'b0, {tag, " idle"}, mk(5'b0, 5'b0, 3'(o), 1'b0, 1'b0));
    endtask

    // bus safety invariants sampled every cycle
    always @(negedge clock) begin
        chk("onehot0 grant", 8'($onehot0(grant)), 8'd1);
        chk("onehot0 drive_en", 8'($onehot0(drive_en)), 8'd1);
        chk("drive_en subset grant", 8'(drive_en & ~grant), 8'd0);
    end

    initial begin
        repeat (2) @(negedge clock);
        compare_all("reset", mk(5'b0, 5'b0, 3'd4, 1'b0, 1'b0));
        reset = 1'b0;

        xfer(5'b00001, REQ_EXEC, 3, "exec");
        step(5'b0, 5'b0, "stay idle", mk(5'b0, 5'b0, 3'd0, 1'b0, 1'b0));

        xfer(5'b10110, REQ_IMEM, 1, "rr1");
        xfer(5'b10110, REQ_MMEM, 1, "rr2");
        xfer(5'b10110, REQ_ALU, 1, "rr4");
        xfer(5'b10110, REQ_IMEM, 1, "rr1 wrap");

        step(5'b00100, 5'b0, "to turn", mk(5'b00100, 5'b0, 3'd2, 1'b1, 1'b0));
        step(5'b00100, 5'b0, "to own", mk(5'b00100, 5'b00100, 3'd2, 1'b1, 1'b0));
        for (int k = 2; k <= 16; k++)
            step(5'b00100, 5'b0, "to hold", mk(5'b00100, 5'b00100, 3'd2, 1'b1, 1'b0));
        step(5'b00100, 5'b0, "to expire", mk(5'b0, 5'b0, 3'd2, 1'b1, 1'b1));
        step(5'b0, 5'b0, "to idle", mk(5'b0, 5'b0, 3'd2, 1'b0, 1'b0));

        step(5'b01000, 5'b0, "late turn", mk(5'b01000, 5'b0, 3'd3, 1'b1, 1'b0));
        step(5'b01000, 5'b01000, "late done in turn", mk(5'b01000, 5'b01000, 3'd3, 1'b1, 1'b0));
        for (int k = 2; k <= 16; k++)
            step(5'b01000, (k % 2 == 0) ? 5'b00001 : 5'b10000, "late foreign done",
                 mk(5'b01000, 5'b01000, 3'd3, 1'b1, 1'b0));
        step(5'b01000, 5'b01000, "late done wins", mk(5'b0, 5'b0, 3'd3, 1'b1, 1'b0));
        step(5'b0, 5'b0, "late idle", mk(5'b0, 5'b0, 3'd3, 1'b0, 1'b0));

        step(5'b00001, 5'b0, "rst turn", mk(5'b00001, 5'b0, 3'd0, 1'b1, 1'b0));
        step(5'b00001, 5'b0, "rst own", mk(5'b00001, 5'b00001, 3'd0, 1'b1, 1'b0));
        #2 reset = 1'b1;
        #1 compare_all("async reset", mk(5'b0, 5'b0, 3'd4, 1'b0, 1'b0));
        @(negedge clock);
        reset = 1'b0;
        xfer(5'b11111, REQ_EXEC, 1, "post reset");

        #1 $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
